// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bitwise gate unit among NREQ requesters.
// Optional LOGIC_ARB_ERR_EN adds res_err, flagging illegal opcodes 6/7.
module logic_op_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [3*NREQ-1:0]         req_op,
   input  logic [WIDTH*NREQ-1:0]     req_a,
   input  logic [WIDTH*NREQ-1:0]     req_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [WIDTH-1:0]          res_data,
   output logic [$clog2(NREQ)-1:0]   res_id,
`ifdef LOGIC_ARB_ERR_EN
   output logic                      res_err,
`endif
   output logic                      busy
);

   localparam int unsigned ID_W = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   winner;
   logic              any_valid;
   logic              grant;
   logic [2:0]        sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;
   logic [2:0]        cap_op;
   logic [WIDTH-1:0]  cap_a;
   logic [WIDTH-1:0]  cap_b;
   logic [ID_W-1:0]   cap_id;
   logic [WIDTH-1:0]  eval_data;
   logic              eval_err;

   // First valid requester at or above ptr, wrapping; lowest offset wins.
   always_comb begin
      int unsigned idx;
      any_valid = 1'b0;
      winner    = '0;
      idx       = 0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx]) begin
            any_valid = 1'b1;
            winner    = ID_W'(idx);
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (winner == ID_W'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[WIDTH*i +: WIDTH];
            sel_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   // Gate unit on captured operands; opcodes 6/7 yield zero.
   always_comb begin
      eval_data = '0;
      eval_err  = 1'b0;
      case (cap_op)
         3'd0:    eval_data = cap_a & cap_b;
         3'd1:    eval_data = cap_a | cap_b;
         3'd2:    eval_data = ~cap_a;
         3'd3:    eval_data = ~(cap_a & cap_b);
         3'd4:    eval_data = ~(cap_a | cap_b);
         3'd5:    eval_data = cap_a ^ cap_b;
         default: eval_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and the combinational grant strobe.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (any_valid && !rst) begin
               grant             = 1'b1;
               req_ready[winner] = 1'b1;
               state_d           = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         cap_op    <= '0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_id    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
`ifdef LOGIC_ARB_ERR_EN
         res_err   <= 1'b0;
`endif
      end else begin
         if (grant) begin
            cap_op <= sel_op;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_id <= winner;
            ptr    <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
         end
         if (state_q == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= eval_data;
            res_id    <= cap_id;
`ifdef LOGIC_ARB_ERR_EN
            res_err   <= eval_err;
`endif
         end else if (state_q == RESP && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifndef LOGIC_ARB_ERR_EN
   logic unused_err;
   assign unused_err = eval_err;
`endif

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter (NREQ=4, WIDTH=8); checks res_err when LOGIC_ARB_ERR_EN is defined.
module tb_logic_op_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [11:0] req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_data;
   logic [1:0]  res_id;
   logic        res_err;
   logic        busy;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic_op_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id),
`ifdef LOGIC_ARB_ERR_EN
      .res_err(res_err),
`endif
      .busy(busy)
   );

`ifndef LOGIC_ARB_ERR_EN
   assign res_err = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   // Scoreboard consumer: compare every completed result handshake.
   always @(negedge clk) begin
      if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected: got id=%0d data=%h, none expected", res_id, res_data);
         end else begin
            mon_e = sb.pop_front();
            if (res_data !== mon_e.data || res_id !== mon_e.id
`ifdef LOGIC_ARB_ERR_EN
                || res_err !== mon_e.err
`endif
               ) begin
               bad++;
               $display("FAIL result: got id=%0d data=%h err=%b, want id=%0d data=%h err=%b",
                        res_id, res_data, res_err, mon_e.id, mon_e.data, mon_e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic send_one(input int id, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e);
      logic [3:0] oh;
      int n;
      oh = 4'b0001 << id;
      @(posedge clk); #1;
      req_op[3*id +: 3] = op;
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
      req_valid[id]     = 1'b1;
      @(negedge clk);
      n = 0;
      while (req_ready === 4'b0000 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (req_ready !== oh) begin
         bad++;
         $display("FAIL grant_req%0d: req_ready=%b want %b", id, req_ready, oh);
      end
      sb.push_back('{id: 2'(id), data: exp_d, err: exp_e});
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      n = 1;
      @(negedge clk);
      while (res_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL latency_req%0d: res_valid after %0d cycles, want 2", id, n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({req_ready, res_valid, res_data, res_id, busy} !== 16'h0000) begin
         bad++;
         $display("FAIL reset: ready=%b valid=%b data=%h id=%0d busy=%b, want all 0",
                  req_ready, res_valid, res_data, res_id, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      res_ready = 1'b1;
      send_one(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
      @(negedge clk);
      drain();
   endtask

   task automatic test_all_ops();
      logic [7:0] want [6];
      want = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA};
      res_ready = 1'b1;
      for (int op = 0; op < 6; op++) begin
         send_one(1, 3'(op), 8'hA5, 8'h0F, want[op], 1'b0);
      end
      drain();
   endtask

   task automatic test_round_robin();
      logic [3:0] oh;
      logic [2:0] op;
      int n;
      int r;
      int last;
      last = 0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      res_ready = 1'b1;
      req_op = 12'($urandom);
      req_a  = $urandom;
      req_b  = $urandom;
      req_valid = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         r = g % 4;
         n = 0;
         @(negedge clk);
         while (req_ready === 4'b0000 && n < 8) begin
            @(negedge clk);
            n++;
         end
         oh = 4'b0001 << r;
         total++;
         if (req_ready !== oh) begin
            bad++;
            $display("FAIL rr_grant%0d: req_ready=%b want %b", g, req_ready, oh);
         end
         if (g > 0) begin
            total++;
            if (cyc - last != 3) begin
               bad++;
               $display("FAIL rr_spacing%0d: %0d cycles between grants, want 3", g, cyc - last);
            end
         end
         last = cyc;
         op = req_op[3*r +: 3];
         sb.push_back('{id: 2'(r), data: model(op, req_a[8*r +: 8], req_b[8*r +: 8]),
                        err: (op >= 3'd6)});
         @(posedge clk); #1;
         if (g == 5) req_valid = 4'b0000;
         else begin
            req_op[3*r +: 3] = 3'($urandom);
            req_a[8*r +: 8]  = 8'($urandom);
            req_b[8*r +: 8]  = 8'($urandom);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      send_one(2, 3'd4, 8'h0C, 8'h30, 8'hC3, 1'b0);
      @(posedge clk); #1;
      req_op[11:9]  = 3'd5;
      req_a[31:24]  = 8'hFF;
      req_b[31:24]  = 8'h0F;
      req_valid[3]  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if ({res_valid, res_data, res_id, req_ready, busy} !== {1'b1, 8'hC3, 2'd2, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL hold%0d: valid=%b data=%h id=%0d ready=%b busy=%b, want 1 c3 2 0000 1",
                     c, res_valid, res_data, res_id, req_ready, busy);
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({req_ready, busy} !== {4'b1000, 1'b0}) begin
         bad++;
         $display("FAIL release: req_ready=%b busy=%b, want 1000 0", req_ready, busy);
      end
      sb.push_back('{id: 2'd3, data: 8'hF0, err: 1'b0});
      @(posedge clk); #1;
      req_valid = 4'b0000;
      drain();
   endtask

   task automatic test_reset_in_resp();
      int n;
      res_ready = 1'b0;
      send_one(1, 3'd1, 8'h11, 8'h22, 8'h33, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete(sb.size() - 1);
      @(posedge clk); #1;
      rst = 1'b0;
      res_ready = 1'b1;
      req_op[2:0]   = 3'd6;
      req_a[7:0]    = 8'hFF;
      req_b[7:0]    = 8'hFF;
      req_op[11:9]  = 3'd0;
      req_a[31:24]  = 8'h0F;
      req_b[31:24]  = 8'hFF;
      req_valid     = 4'b1001;
      @(negedge clk);
      total++;
      if ({res_valid, res_data, req_ready} !== {1'b0, 8'h00, 4'b0001}) begin
         bad++;
         $display("FAIL post_reset: valid=%b data=%h ready=%b, want 0 00 0001",
                  res_valid, res_data, req_ready);
      end
      sb.push_back('{id: 2'd0, data: 8'h00, err: 1'b1});
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (req_ready === 4'b0000 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL after_illegal: req_ready=%b want 1000", req_ready);
      end
      sb.push_back('{id: 2'd3, data: 8'h0F, err: 1'b0});
      @(posedge clk); #1;
      req_valid = 4'b0000;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_ops();
      test_round_robin();
      test_backpressure();
      test_reset_in_resp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
